// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural Z/V/N flag register, branch condition
// resolution, registered branch-taken pulse and fixed-length pipeline flush.
// Optional feature macro: FLAG_FWD_EN -- when defined, branch conditions see
// flag writes from the same cycle (per-bit bypass of flags_in over flags_q).
module flag_branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] flags_in,
    input  logic [2:0] flags_en,
    input  logic       stall,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    output logic [2:0] flags_q,
    output logic       br_taken,
    output logic       flush,
    output logic       br_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int unsigned ZB = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned NB = 0;

    // Counter reload: flush spans FLUSH_CYCLES cycles including the entry cycle.
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       br_taken_q, br_taken_d;
    logic       flush_q, flush_d;
    logic [2:0] flags_d;
    logic [2:0] eval_flags;
    logic       cond_true;
    logic       accept;

    // Flags the branch condition is resolved against.
    always_comb begin
`ifdef FLAG_FWD_EN
        // Bypass applies regardless of stall; acceptance still needs !stall.
        eval_flags = (flags_en & flags_in) | (~flags_en & flags_q);
`else
        eval_flags = flags_q;
`endif
    end

    // Condition-code decode.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = !eval_flags[ZB];
            3'b001:  cond_true = eval_flags[ZB];
            3'b010:  cond_true = !eval_flags[ZB] && !eval_flags[NB];
            3'b011:  cond_true = eval_flags[NB];
            3'b100:  cond_true = eval_flags[ZB] || !eval_flags[NB];
            3'b101:  cond_true = eval_flags[ZB] || eval_flags[NB];
            3'b110:  cond_true = eval_flags[VB];
            default: cond_true = 1'b1;
        endcase
    end

    // Independent per-bit flag writes, all frozen by stall.
    always_comb begin
        flags_d = flags_q;
        if (!stall) begin
            flags_d = (flags_en & flags_in) | (~flags_en & flags_q);
        end
    end

    assign accept = br_valid && !stall && (state_q == IDLE);

    // Branch/flush FSM next-state; stall never pauses the flush countdown.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        br_taken_d = 1'b0;
        flush_d    = flush_q;
        case (state_q)
            IDLE: begin
                flush_d = 1'b0;
                if (accept && cond_true) begin
                    state_d    = FLUSH;
                    cnt_d      = CNT_LOAD;
                    br_taken_d = 1'b1;
                    flush_d    = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any flush immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            br_taken_q <= 1'b0;
            flush_q    <= 1'b0;
            flags_q    <= 3'b000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            br_taken_q <= br_taken_d;
            flush_q    <= flush_d;
            flags_q    <= flags_d;
        end
    end

    assign br_taken = br_taken_q;
    assign flush    = flush_q;
    assign br_busy  = (state_q == FLUSH);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit (built with FLUSH_CYCLES=3).
module tb_flag_branch_unit;

    localparam int unsigned FC = 3;

    logic       clk;
    logic       rst;
    logic [2:0] flags_in;
    logic [2:0] flags_en;
    logic       stall;
    logic       br_valid;
    logic [2:0] br_cond;
    logic [2:0] flags_q;
    logic       br_taken;
    logic       flush;
    logic       br_busy;

    int checks;
    int errors;

    flag_branch_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk      (clk),
        .rst      (rst),
        .flags_in (flags_in),
        .flags_en (flags_en),
        .stall    (stall),
        .br_valid (br_valid),
        .br_cond  (br_cond),
        .flags_q  (flags_q),
        .br_taken (br_taken),
        .flush    (flush),
        .br_busy  (br_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table; f = {Z,V,N}.
    function automatic logic exp_cond(input logic [2:0] f, input logic [2:0] c);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flags_in = 3'b000; flags_en = 3'b000; stall = 1'b0;
        br_valid = 1'b0;   br_cond = 3'b000;
    endtask

    // Wait (bounded) until the flush has drained.
    task automatic drain();
        int n;
        idle_inputs();
        n = 0;
        while (br_busy && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (br_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout br_busy=%b required 0", br_busy);
        end
    endtask

    task automatic write_flags(input logic [2:0] v);
        idle_inputs();
        flags_in = v; flags_en = 3'b111;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        checks++;
        if ({flags_q, br_taken, flush, br_busy} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_state flags=%b taken=%b flush=%b busy=%b required all 0",
                     flags_q, br_taken, flush, br_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: flags=%b taken=%b flush=%b busy=%b", flags_q, br_taken, flush, br_busy);
    endtask

    task automatic test_flag_enables();
        write_flags(3'b000);
        flags_in = 3'b111; flags_en = 3'b101;
        step();
        checks++;
        if (flags_q !== 3'b101) begin
            errors++;
            $display("FAIL flag_en_write flags_q=%b required 101", flags_q);
        end
        $display("flag write in=111 en=101 -> flags_q=%b", flags_q);
        flags_in = 3'b010; flags_en = 3'b111; stall = 1'b1;
        step();
        checks++;
        if (flags_q !== 3'b101) begin
            errors++;
            $display("FAIL flag_stall_hold flags_q=%b required 101", flags_q);
        end
        $display("flag write under stall -> flags_q=%b", flags_q);
        idle_inputs();
    endtask

    task automatic test_cond_sweep();
        logic exp;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                write_flags(3'(f));
                br_valid = 1'b1; br_cond = 3'(c);
                step();
                exp = exp_cond(3'(f), 3'(c));
                checks++;
                if (br_taken !== exp || flush !== exp) begin
                    errors++;
                    $display("FAIL cond_f%0d_c%0d taken=%b flush=%b required %b", f, c, br_taken, flush, exp);
                end
                $display("cond flags=%b code=%b -> taken=%b", 3'(f), 3'(c), br_taken);
                drain();
            end
        end
    endtask

    task automatic test_flush_length();
        logic [2:0] got_t, got_f, got_b;
        idle_inputs();
        br_valid = 1'b1; br_cond = 3'b111;
        // Edge k; br_valid held high during flush must be ignored.
        for (int i = 0; i < 3; i++) begin
            step();
            got_t[i] = br_taken; got_f[i] = flush; got_b[i] = br_busy;
        end
        checks++;
        if (got_t !== 3'b001 || got_f !== 3'b111 || got_b !== 3'b111) begin
            errors++;
            $display("FAIL flush_span taken=%b flush=%b busy=%b required 001/111/111", got_t, got_f, got_b);
        end
        step();
        checks++;
        if ({br_taken, flush, br_busy} !== 3'b000) begin
            errors++;
            $display("FAIL flush_end taken=%b flush=%b busy=%b required 000", br_taken, flush, br_busy);
        end
        step();
        checks++;
        if (br_taken !== 1'b1) begin
            errors++;
            $display("FAIL flush_next_accept taken=%b required 1", br_taken);
        end
        $display("flush length: taken=%b flush=%b busy=%b", got_t, got_f, got_b);
        drain();
    endtask

    task automatic test_forwarding();
        logic exp;
`ifdef FLAG_FWD_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        write_flags(3'b000);
        flags_in = 3'b100; flags_en = 3'b100; br_valid = 1'b1; br_cond = 3'b001;
        step();
        checks++;
        if (br_taken !== exp) begin
            errors++;
            $display("FAIL fwd_taken taken=%b required %b", br_taken, exp);
        end
        checks++;
        if (flags_q !== 3'b100) begin
            errors++;
            $display("FAIL fwd_flags flags_q=%b required 100", flags_q);
        end
        $display("same-cycle write+EQ -> taken=%b flags_q=%b", br_taken, flags_q);
        drain();
    endtask

    task automatic test_stall();
        int n;
        idle_inputs();
        br_valid = 1'b1; br_cond = 3'b111; stall = 1'b1;
        step();
        checks++;
        if (br_taken !== 1'b0 || br_busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_block taken=%b busy=%b required 0/0", br_taken, br_busy);
        end
        stall = 1'b0;
        step();
        checks++;
        if (br_taken !== 1'b1) begin
            errors++;
            $display("FAIL stall_release taken=%b required 1", br_taken);
        end
        br_valid = 1'b0; stall = 1'b1;
        n = 1;
        while (flush && n < 20) begin
            step();
            if (flush) n++;
        end
        checks++;
        if (n != FC) begin
            errors++;
            $display("FAIL stall_flush_len cycles=%0d required %0d", n, FC);
        end
        $display("stall during flush -> flush cycles=%0d", n);
        drain();
    endtask

    task automatic test_back_to_back();
        write_flags(3'b000);
        br_valid = 1'b1; br_cond = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (br_taken !== 1'b0 || br_busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_nt%0d taken=%b busy=%b required 0/0", i, br_taken, br_busy);
            end
            $display("back-to-back not-taken %0d -> taken=%b", i, br_taken);
        end
        br_cond = 3'b000;
        step();
        checks++;
        if (br_taken !== 1'b1) begin
            errors++;
            $display("FAIL b2b_taken taken=%b required 1", br_taken);
        end
        $display("back-to-back then NE -> taken=%b", br_taken);
        drain();
    endtask

    task automatic test_async_reset();
        write_flags(3'b111);
        br_valid = 1'b1; br_cond = 3'b111;
        step();
        br_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({flags_q, br_taken, flush, br_busy} !== 6'b000000) begin
            errors++;
            $display("FAIL async_reset flags=%b taken=%b flush=%b busy=%b required all 0",
                     flags_q, br_taken, flush, br_busy);
        end
        $display("async reset mid-flush -> flags=%b flush=%b busy=%b", flags_q, flush, br_busy);
        @(negedge clk);
        rst = 1'b0;
        br_valid = 1'b1; br_cond = 3'b111;
        step();
        checks++;
        if (br_taken !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_branch taken=%b required 1", br_taken);
        end
        drain();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_flag_enables();
        test_cond_sweep();
        test_flush_length();
        test_forwarding();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
